// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and encodings for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == SIZE_BYTE || s == SIZE_HALF) ? s : SIZE_WORD;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// arb_rr2: two-way round-robin pick; a tie goes to whichever side was not served last
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic i_req_if,
  input  logic i_req_dm,
  input  logic i_last,
  output logic o_any,
  output logic o_pick
);
  assign o_any  = i_req_if | i_req_dm;
  assign o_pick = (i_req_dm && (!i_req_if || i_last == OWN_IF)) ? OWN_DM : OWN_IF;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between fetch and load/store,
// one transaction at a time, with a watchdog that aborts hung transactions
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic              o_if_err,
  output logic [31:0]       o_if_rdata,
  input  logic              i_dm_req,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic              i_dm_we,
  input  logic [1:0]        i_dm_size,
  input  logic [31:0]       i_dm_wdata,
  output logic              o_dm_gnt,
  output logic              o_dm_rvalid,
  output logic              o_dm_err,
  output logic [31:0]       o_dm_rdata,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [1:0]        o_mem_size,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t            r_state;
  logic              r_last, r_owner, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [31:0]       r_wdata, r_if_rdata, r_dm_rdata;
  logic [CW-1:0]     r_cnt;
  logic              r_if_rvalid, r_if_err, r_dm_rvalid, r_dm_err;
  logic              w_any, w_pick, w_start, w_done, w_tout;
  arb_rr2 u_arb (
    .i_req_if(i_if_req),
    .i_req_dm(i_dm_req),
    .i_last  (r_last),
    .o_any   (w_any),
    .o_pick  (w_pick)
  );
  // grant is combinational but suppressed while reset is being applied
  assign w_start     = i_rst_n && r_state == ST_IDLE && w_any;
  assign w_done      = r_state == ST_WAIT && i_mem_rvalid;
  assign w_tout      = r_state != ST_IDLE && r_cnt == CW'(TIMEOUT_CYCLES - 1) && !w_done;
  assign o_if_gnt    = w_start && w_pick == OWN_IF;
  assign o_dm_gnt    = w_start && w_pick == OWN_DM;
  assign o_mem_req   = r_state == ST_ISSUE;
  assign o_mem_addr  = r_addr;
  assign o_mem_we    = r_we;
  assign o_mem_size  = r_size;
  assign o_mem_wdata = r_wdata;
  assign o_busy      = r_state != ST_IDLE;
  assign o_if_rvalid = r_if_rvalid;
  assign o_if_err    = r_if_err;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rvalid = r_dm_rvalid;
  assign o_dm_err    = r_dm_err;
  assign o_dm_rdata  = r_dm_rdata;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_last      <= OWN_IF;
      r_owner     <= OWN_IF;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_wdata     <= '0;
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rvalid <= 1'b0;
      r_dm_err    <= 1'b0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_dm_err    <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_state <= ST_ISSUE;
          r_cnt   <= '0;
          r_owner <= w_pick;
          r_addr  <= (w_pick == OWN_DM) ? i_dm_addr : i_if_addr;
          r_we    <= (w_pick == OWN_DM) && i_dm_we;
          r_size  <= (w_pick == OWN_DM) ? norm_size(i_dm_size) : SIZE_WORD;
          r_wdata <= (w_pick == OWN_DM) ? i_dm_wdata : '0;
        end
        ST_ISSUE: begin
          r_cnt <= r_cnt + 1'b1;
          if (i_mem_gnt) r_state <= ST_WAIT;
        end
        default: r_cnt <= r_cnt + 1'b1;
      endcase
      // completion and abort both retire the transaction; abort returns zero data
      if (w_done || w_tout) begin
        r_state <= ST_IDLE;
        r_last  <= r_owner;
        if (r_owner == OWN_DM) begin
          r_dm_rvalid <= 1'b1;
          r_dm_err    <= w_tout;
          r_dm_rdata  <= (w_done && !r_we) ? i_mem_rdata : '0;
        end else begin
          r_if_rvalid <= 1'b1;
          r_if_err    <= w_tout;
          r_if_rdata  <= w_done ? i_mem_rdata : '0;
        end
      end
    end
  end
endmodule
